timer_unit: RTL and testbench

- Consumes the 4 MHz system clock domain and owns the free-running divider plus the programmable timer: DIV (FF04), TIMA (FF05), TMA (FF06), TAC (FF07).
- Sits directly downstream of the clock/reset/divider generation stage. It replaces the gate-level divider taps (16384/65536/262144/4096 Hz) with a synchronous RTL model clocked at the T-cycle rate.
- Raises the timer interrupt request toward the interrupt controller.

---
 rtl/timer_pkg.sv | 27 ++
 rtl/timer_edge_detect.sv | 18 +
 rtl/timer_unit.sv | 131 +++++++++++++
 tb/tb_timer_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Register map, FSM encoding and divider tap lookup shared by the timer block.
package timer_pkg;

  localparam logic [1:0] REG_DIV  = 2'd0;
  localparam logic [1:0] REG_TIMA = 2'd1;
  localparam logic [1:0] REG_TMA  = 2'd2;
  localparam logic [1:0] REG_TAC  = 2'd3;

  localparam logic [7:0] TAC_UNUSED_MASK = 8'hF8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    OVF    = 2'd1,
    RELOAD = 2'd2
  } timer_state_e;

  // Divider bit feeding TIMA for each TAC clock-select code.
  function automatic logic [3:0] tap_bit(input logic [1:0] clk_sel);
    case (clk_sel)
      2'b00:   tap_bit = 4'd9;
      2'b01:   tap_bit = 4'd3;
      2'b10:   tap_bit = 4'd5;
      default: tap_bit = 4'd7;
    endcase
  endfunction

endpackage

// File: rtl/timer_edge_detect.sv
// Registers a level and flags its falling edge combinationally in the following clk.
module timer_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (reset) sig_q <= 1'b0;
    else       sig_q <= sig_i;
  end

  assign fall_o = sig_q & ~sig_i;

endmodule

// File: rtl/timer_unit.sv
// DIV/TIMA/TMA/TAC timer with delayed TMA reload and IRQ; one register write per clk, no backpressure.
// DIV_APU_EVENT_EN adds div_apu_tick, a pulse on each falling edge of div[12].
module timer_unit
  import timer_pkg::*;
#(
  parameter int DIV_WIDTH    = 16,
  parameter int RELOAD_DELAY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           addr,
  input  logic                 sel,
  input  logic                 wr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata,
  output logic                 irq_timer,
  output logic [DIV_WIDTH-1:0] div_bits
`ifdef DIV_APU_EVENT_EN
  ,
  output logic                 div_apu_tick
`endif
);

  localparam int CNT_W = (RELOAD_DELAY > 2) ? $clog2(RELOAD_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RELOAD_DELAY - 1);

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [7:0]           tima_q, tima_d;
  logic [7:0]           tma_q, tma_d;
  logic [2:0]           tac_q, tac_d;
  timer_state_e         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic wr_div, wr_tima, wr_tma, wr_tac;
  logic tap_sig, tima_inc;

  assign wr_div  = sel & wr & (addr == REG_DIV);
  assign wr_tima = sel & wr & (addr == REG_TIMA);
  assign wr_tma  = sel & wr & (addr == REG_TMA);
  assign wr_tac  = sel & wr & (addr == REG_TAC);

  // DIV clears, TAC disables and tap switches all show up as falling edges here.
  assign tap_sig = tac_q[2] & div_q[tap_bit(tac_q[1:0])];

  timer_edge_detect u_tima_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (tap_sig),
    .fall_o (tima_inc)
  );

`ifdef DIV_APU_EVENT_EN
  timer_edge_detect u_apu_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (div_q[12]),
    .fall_o (div_apu_tick)
  );
`endif

  always_comb begin
    div_d   = wr_div ? '0 : div_q + 1'b1;
    tma_d   = wr_tma ? wdata : tma_q;
    tac_d   = wr_tac ? wdata[2:0] : tac_q;
    tima_d  = tima_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (wr_tima) begin
          tima_d = wdata;
        end else if (tima_inc) begin
          tima_d = tima_q + 1'b1;
          if (tima_q == 8'hFF) begin
            state_d = OVF;
            cnt_d   = CNT_INIT;
          end
        end
      end
      OVF: begin
        if (wr_tima) begin
          tima_d  = wdata;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = RELOAD;
        end
      end
      RELOAD: begin
        // Same-clk TMA write is forwarded; TIMA writes are dropped.
        tima_d  = tma_d;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      tima_q  <= 8'h00;
      tma_q   <= 8'h00;
      tac_q   <= 3'b000;
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      div_q   <= div_d;
      tima_q  <= tima_d;
      tma_q   <= tma_d;
      tac_q   <= tac_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    rdata = 8'hFF;
    if (sel) begin
      case (addr)
        REG_DIV:  rdata = div_q[15:8];
        REG_TIMA: rdata = tima_q;
        REG_TMA:  rdata = tma_q;
        default:  rdata = TAC_UNUSED_MASK | {5'b00000, tac_q};
      endcase
    end
  end

  assign irq_timer = (state_q == RELOAD);
  assign div_bits  = div_q;

endmodule

// File: tb/tb_timer_unit.sv
// Randomized and directed bench for timer_unit against a cycle-level behavioural model.
module tb_timer_unit;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        sel;
  logic        wr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        irq_timer;
  logic [15:0] div_bits;
`ifdef DIV_APU_EVENT_EN
  logic        div_apu_tick;
  logic        obs_tick;
`endif

  timer_unit #(.DIV_WIDTH(16), .RELOAD_DELAY(RD)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .sel       (sel),
    .wr        (wr),
    .wdata     (wdata),
    .rdata     (rdata),
    .irq_timer (irq_timer),
    .div_bits  (div_bits)
`ifdef DIV_APU_EVENT_EN
    ,
    .div_apu_tick (div_apu_tick)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: architectural registers plus "cycles since overflow" for the pending reload.
  logic [15:0] m_div;
  logic [7:0]  m_tima, m_tma;
  logic [2:0]  m_tac;
  bit          m_sigprev, m_apuprev, m_pend;
  int          m_age;
  int          taps[4] = '{9, 3, 5, 7};

  logic [15:0] pre_div;
  logic [7:0]  obs_rdata;
  logic        obs_irq;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_read(input bit s, input logic [1:0] a);
    if (!s) return 8'hFF;
    case (a)
      2'd0:    return m_div[15:8];
      2'd1:    return m_tima;
      2'd2:    return m_tma;
      default: return {5'b11111, m_tac};
    endcase
  endfunction

  task automatic model_edge(input bit rst, input bit s, input bit w, input logic [1:0] a,
                            input logic [7:0] d, input bit sig_now);
    bit fall;
    logic [7:0] new_tma;
    if (rst) begin
      m_div = 16'h0; m_tima = 8'h0; m_tma = 8'h0; m_tac = 3'b0;
      m_sigprev = 1'b0; m_apuprev = 1'b0; m_pend = 1'b0; m_age = 0;
      return;
    end
    fall    = m_sigprev & ~sig_now;
    new_tma = (s && w && a == 2'd2) ? d : m_tma;
    if (m_pend) begin
      if (m_age == RD - 1) begin
        m_tima = new_tma; m_pend = 1'b0;
      end else if (s && w && a == 2'd1) begin
        m_tima = d; m_pend = 1'b0;
      end else begin
        m_age++;
      end
    end else if (s && w && a == 2'd1) begin
      m_tima = d;
    end else if (fall) begin
      if (m_tima == 8'hFF) begin
        m_tima = 8'h00; m_pend = 1'b1; m_age = 0;
      end else begin
        m_tima = m_tima + 8'd1;
      end
    end
    m_tma = new_tma;
    if (s && w && a == 2'd3) m_tac = d[2:0];
    m_apuprev = m_div[12];
    m_div     = (s && w && a == 2'd0) ? 16'h0 : m_div + 16'd1;
    m_sigprev = sig_now;
  endtask

  task automatic step(input bit rst, input bit s, input bit w, input logic [1:0] a,
                      input logic [7:0] d);
    bit sig_now;
    @(negedge clk);
    reset = rst; sel = s; wr = w; addr = a; wdata = d;
    #1;
    sig_now   = m_tac[2] & m_div[taps[m_tac[1:0]]];
    pre_div   = m_div;
    obs_rdata = rdata;
    obs_irq   = irq_timer;
    check("rdata", 16'(rdata), 16'(exp_read(s, a)));
    check("irq", 16'(irq_timer), 16'(m_pend && m_age == RD - 1));
    check("div_bits", div_bits, m_div);
`ifdef DIV_APU_EVENT_EN
    obs_tick = div_apu_tick;
    check("apu_tick", 16'(div_apu_tick), 16'(m_apuprev & ~m_div[12]));
`endif
    @(posedge clk);
    model_edge(rst, s, w, a, d, sig_now);
  endtask

  initial begin
    int irqs, zeros;
    bit chk_next, done;
    logic [7:0] t0;

    reset = 1'b1; sel = 1'b0; wr = 1'b0; addr = 2'd0; wdata = 8'h00;
    repeat (2) @(posedge clk);
    model_edge(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);

    // Reset values and the deselected read.
    step(0, 1, 0, 2'd3, 8'h00);
    check("rst_tac", 16'(obs_rdata), 16'h00F8);
    step(0, 0, 0, 2'd1, 8'h00);
    check("nosel_ff", 16'(obs_rdata), 16'h00FF);
    step(1, 0, 0, 2'd0, 8'h00);

    // TAC=101 written while div==0: first increment visible at div 0x11, 0x10 by div 0x101.
    step(0, 1, 1, 2'd3, 8'h05);
    for (int i = 0; i < 300; i++) begin
      step(0, 1, 0, 2'd1, 8'h00);
      if (pre_div == 16'h0010) check("tima_before_edge", 16'(obs_rdata), 16'h0000);
      if (pre_div == 16'h0011) check("tima_first_inc", 16'(obs_rdata), 16'h0001);
      if (pre_div == 16'h0101) check("tima_after_256", 16'(obs_rdata), 16'h0010);
    end

    // Plain overflow and reload.
    step(0, 1, 1, 2'd2, 8'hF0);
    step(0, 1, 1, 2'd1, 8'hFF);
    irqs = 0; zeros = 0; chk_next = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 0, 2'd1, 8'h00);
      if (chk_next) begin check("reload_val", 16'(obs_rdata), 16'h00F0); chk_next = 1'b0; end
      if (obs_rdata == 8'h00) zeros++;
      if (obs_irq) begin
        irqs++;
        check("irq_tima_zero", 16'(obs_rdata), 16'h0000);
        chk_next = 1'b1;
      end
    end
    check("ovf_zero_clks", 16'(zeros), 16'd4);
    check("ovf_irq_count", 16'(irqs), 16'd1);

    // TIMA write on the second OVF clk cancels the reload.
    step(0, 1, 1, 2'd1, 8'hFF);
    irqs = 0; done = 1'b0; chk_next = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_pend && m_age == 1 && !done) begin
        step(0, 1, 1, 2'd1, 8'h42);
        done = 1'b1; chk_next = 1'b1;
      end else begin
        step(0, 1, 0, 2'd1, 8'h00);
        if (chk_next) begin check("cancel_val", 16'(obs_rdata), 16'h0042); chk_next = 1'b0; end
      end
      if (obs_irq) irqs++;
    end
    check("cancel_seen", 16'(done), 16'd1);
    check("cancel_irq", 16'(irqs), 16'd0);

    // TMA write in the RELOAD clk is what lands in TIMA.
    step(0, 1, 1, 2'd1, 8'hFF);
    irqs = 0; done = 1'b0; chk_next = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_pend && m_age == RD - 1 && !done) begin
        step(0, 1, 1, 2'd2, 8'h77);
        done = 1'b1; chk_next = 1'b1;
      end else begin
        step(0, 1, 0, 2'd1, 8'h00);
        if (chk_next) begin check("reload_tma_wr", 16'(obs_rdata), 16'h0077); chk_next = 1'b0; end
      end
      if (obs_irq) irqs++;
    end
    check("reload_seen", 16'(done), 16'd1);
    check("reload_irq", 16'(irqs), 16'd1);

    // DIV write while the selected tap is high gives one glitch increment.
    step(0, 1, 1, 2'd3, 8'h04);
    step(0, 1, 1, 2'd1, 8'h10);
    for (int i = 0; i < 2100 && !m_div[9]; i++) step(0, 1, 0, 2'd1, 8'h00);
    check("div9_reached", 16'(m_div[9]), 16'd1);
    step(0, 1, 0, 2'd1, 8'h00);
    t0 = obs_rdata;
    step(0, 1, 1, 2'd0, 8'h5A);
    step(0, 1, 0, 2'd0, 8'h00);
    check("div_cleared", 16'(obs_rdata), 16'h0000);
    step(0, 1, 0, 2'd1, 8'h00);
    check("glitch_inc", 16'(obs_rdata), 16'(t0 + 8'd1));

`ifdef DIV_APU_EVENT_EN
    begin
      logic [15:0] first_div;
      bit seen;
      seen = 1'b0; first_div = 16'h0;
      step(1, 0, 0, 2'd0, 8'h00);
      for (int i = 0; i < 16'h2100; i++) begin
        step(0, 1, 0, 2'd0, 8'h00);
        if (obs_tick && !seen) begin seen = 1'b1; first_div = pre_div; end
      end
      check("apu_first_div", first_div, 16'h2000);
      step(0, 1, 1, 2'd0, 8'h00);
      step(0, 1, 0, 2'd0, 8'h00);
      check("apu_div_write", 16'(obs_tick), 16'd1);
    end
`endif

    // Random traffic: mostly reads, writes biased to reach overflow, rare resets.
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [1:0] a;
      logic [7:0] d;
      r = $urandom_range(0, 199);
      a = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      if (r == 0) begin
        step(1, 0, 0, a, d);
      end else if (r < 30) begin
        if (a == 2'd0 && $urandom_range(0, 3) != 0) a = 2'd1;
        if (a == 2'd1 && d[0]) d = d | 8'hF8;
        if (a == 2'd2 && d[1]) d = d | 8'hF0;
        step(0, 1, 1, a, d);
      end else begin
        step(0, $urandom_range(0, 9) != 0, 0, a, d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
